mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIM, default 4: consecutive inst-request losses before inst is forced to win one grant.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 resetn  in  1  reset is asynchronous and active-low; all state clears immediately when low.
REQ-004 inst_req  in  1  fetch requester asks for a read.
REQ-005 inst_addr  in  32  fetch byte address.
REQ-006 inst_addr_ok  out  1  fetch request accepted this cycle.
REQ-007 inst_data_ok  out  1  fetch read data valid this cycle.
REQ-008 inst_rdata  out  32  fetch read data.
REQ-009 data_req  in  1  load/store requester asks for an access.
REQ-010 data_wr  in  1  1 = store, 0 = load.
REQ-011 data_size  in  2  access size: 0 byte, 1 half, 2 word.
REQ-012 data_wstrb  in  4  store byte enables.
REQ-013 data_addr / data_wdata  in  32 / 32  access address, store data.
REQ-014 data_addr_ok / data_data_ok  out  1 / 1  accepted this cycle / response this cycle.
REQ-015 data_rdata  out  32  load data.
REQ-016 mem_en / mem_wen  out  1 / 4  unified single-port SRAM enable, byte write enables.
REQ-017 mem_addr / mem_wdata / mem_size  out  32 / 32 / 2  SRAM address, write data, size.
REQ-018 mem_rdata  in  32  SRAM read data, valid exactly one cycle after mem_en.

Function
REQ-019 At most one request SHALL be granted per cycle; a grant asserts mem_en and the winner's addr_ok combinationally in the same cycle.
REQ-020 Default priority SHALL be data over inst.
REQ-021 A starvation counter (width clog2(STARVE_LIM)+1) SHALL increment each cycle inst_req=1 and data wins; clear on inst grant or inst_req=0; saturate at STARVE_LIM.
REQ-022 When counter == STARVE_LIM and both request, inst SHALL win; counter then clears.
REQ-023 inst grant: mem_wen=0, mem_size=2, mem_addr=inst_addr, mem_wdata=0.
REQ-024 data grant: mem_addr=data_addr, mem_size=data_size, mem_wdata=data_wdata, mem_wen=data_wr ? data_wstrb : 0.
REQ-025 No grant: mem_en=0, mem_wen=0; mem_addr/mem_wdata/mem_size don't-care, driven 0.
REQ-026 Response register (rsp_valid, rsp_owner) SHALL capture each grant; cycle N grant -> owner's data_ok=1 in cycle N+1 for one cycle, other data_ok=0.
REQ-027 Stores SHALL also return data_ok in N+1 (write completion); data_rdata then don't-care.
REQ-028 inst_rdata and data_rdata SHALL both be driven from mem_rdata; only the data_ok qualifies them.
REQ-029 Back-to-back grants SHALL sustain one access per cycle with no bubble; a grant in N+1 overlaps the N response.
REQ-030 addr_ok SHALL never assert without the matching req in the same cycle.

Reset
REQ-031 resetn low: all addr_ok, data_ok, mem_en, mem_wen = 0; mem_addr, mem_wdata, mem_size = 0; counter = 0; rsp_valid = 0.
REQ-032 Reset mid-operation: an in-flight response SHALL be discarded, no data_ok after resetn rises; first grant allowed in the first cycle resetn is high.

Verification
REQ-033 inst_req only, addr 0x1C000000, mem_rdata 0x02800C0C next cycle -> inst_addr_ok cycle 0, inst_data_ok=1 and inst_rdata=0x02800C0C cycle 1.
REQ-034 Both req held, STARVE_LIM=4 -> grants D,D,D,D,I,D,D,D,D,I; inst_addr_ok exactly every 5th cycle.
REQ-035 data store addr 0x1000, wstrb 4'b0011, wdata 0xABCD1234, size 1 -> mem_wen=0011, mem_size=1 same cycle; data_data_ok next cycle, inst_data_ok=0.
REQ-036 Alternating inst/data load stream 8 cycles -> 8 grants, 8 data_ok with correct owner each N+1, zero idle mem_en cycles.
REQ-037 resetn pulled low in cycle after a data load grant -> no data_data_ok, all outputs 0 during reset, counter 0.
REQ-038 inst_req held, data_req dropped after 3 wins -> counter clears, inst granted in the next cycle.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch and load/store requesters, the arbiter and the unified SRAM.
// The arbiter uses the slave modport. The environment (requesters plus SRAM) uses the master modport.
interface mem_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic [31:0] mem_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_en, mem_wen, mem_addr, mem_wdata, mem_size,
    input  mem_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_en, mem_wen, mem_addr, mem_wdata, mem_size,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter for one single-port SRAM. Data wins by default, and a starvation
// counter forces a fetch grant. Responses return exactly one cycle after the grant.
module mem_arbiter #(
  parameter int STARVE_LIM = 4
) (
  input  logic           clk,
  input  logic           resetn,
  mem_arbiter_if.slave   bus
);

  localparam int            CW  = $clog2(STARVE_LIM) + 1;
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_DATA = 2'b01,
    GNT_INST = 2'b10
  } gnt_e;

  gnt_e          gnt_s;
  logic [CW-1:0] starve_cnt_r;
  logic [CW-1:0] starve_cnt_nxt_s;
  logic          rsp_valid_r;
  logic          rsp_owner_r;   // 1 = inst, 0 = data

  // Grant selection. While resetn is low, no grant is issued.
  always_comb begin
    gnt_s = GNT_NONE;
    if (resetn) begin
      if (bus.inst_req && (!bus.data_req || (starve_cnt_r == LIM))) begin
        gnt_s = GNT_INST;
      end else if (bus.data_req) begin
        gnt_s = GNT_DATA;
      end else begin
        gnt_s = GNT_NONE;
      end
    end else begin
      gnt_s = GNT_NONE;
    end
  end

  // Next value of the starvation counter. It counts fetch losses and saturates at the limit.
  always_comb begin
    starve_cnt_nxt_s = starve_cnt_r;
    if (!bus.inst_req || (gnt_s == GNT_INST)) begin
      starve_cnt_nxt_s = {CW{1'b0}};
    end else if ((gnt_s == GNT_DATA) && (starve_cnt_r != LIM)) begin
      starve_cnt_nxt_s = starve_cnt_r + CW'(1);
    end else begin
      starve_cnt_nxt_s = starve_cnt_r;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt_r <= {CW{1'b0}};
    end else begin
      starve_cnt_r <= starve_cnt_nxt_s;
    end
  end

  // Response tracking. Every grant, including a store, produces one data_ok in the next cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_valid_r <= 1'b0;
      rsp_owner_r <= 1'b0;
    end else begin
      rsp_valid_r <= (gnt_s != GNT_NONE);
      rsp_owner_r <= (gnt_s == GNT_INST);
    end
  end

  // SRAM request mux and accept strobes. These are combinational, so a grant costs no latency.
  always_comb begin
    bus.mem_en       = 1'b0;
    bus.mem_wen      = 4'b0000;
    bus.mem_addr     = 32'h0000_0000;
    bus.mem_wdata    = 32'h0000_0000;
    bus.mem_size     = 2'b00;
    bus.inst_addr_ok = 1'b0;
    bus.data_addr_ok = 1'b0;
    case (gnt_s)
      GNT_INST: begin
        bus.mem_en       = 1'b1;
        bus.mem_addr     = bus.inst_addr;
        bus.mem_size     = 2'd2;
        bus.inst_addr_ok = 1'b1;
      end
      GNT_DATA: begin
        bus.mem_en       = 1'b1;
        bus.mem_wen      = bus.data_wr ? bus.data_wstrb : 4'b0000;
        bus.mem_addr     = bus.data_addr;
        bus.mem_wdata    = bus.data_wdata;
        bus.mem_size     = bus.data_size;
        bus.data_addr_ok = 1'b1;
      end
      default: begin
        bus.mem_en = 1'b0;
      end
    endcase
  end

  assign bus.inst_data_ok = rsp_valid_r & rsp_owner_r;
  assign bus.data_data_ok = rsp_valid_r & ~rsp_owner_r;
  assign bus.inst_rdata   = bus.mem_rdata;
  assign bus.data_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with STARVE_LIM = 4.
// Inputs change 1 ns after each rising edge, and outputs are sampled 3 ns later.
module tb_mem_arbiter;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIM(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, "_iaok"}, bus.inst_addr_ok, 32'd0);
    chk({tag, "_daok"}, bus.data_addr_ok, 32'd0);
    chk({tag, "_en"},   bus.mem_en,       32'd0);
    chk({tag, "_wen"},  bus.mem_wen,      32'd0);
    chk({tag, "_addr"}, bus.mem_addr,     32'd0);
    chk({tag, "_wd"},   bus.mem_wdata,    32'd0);
    chk({tag, "_size"}, bus.mem_size,     32'd0);
  endtask

  // Both requesters assert. The task checks the winner and the response for the previous grant.
  task automatic step_both(input string tag, input logic exp_i,
                           input logic prev_v, input logic prev_i);
    bus.inst_req = 1'b1;
    bus.data_req = 1'b1;
    #3;
    chk({tag, "_iaok"}, bus.inst_addr_ok, {31'd0, exp_i});
    chk({tag, "_daok"}, bus.data_addr_ok, {31'd0, ~exp_i});
    chk({tag, "_en"},   bus.mem_en,       32'd1);
    chk({tag, "_addr"}, bus.mem_addr,     exp_i ? 32'h0000_0100 : 32'h0000_0200);
    chk({tag, "_idok"}, bus.inst_data_ok, {31'd0, prev_v & prev_i});
    chk({tag, "_ddok"}, bus.data_data_ok, {31'd0, prev_v & ~prev_i});
    next_cycle();
  endtask

  initial begin
    logic p_v;
    logic p_i;
    logic e_i;
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    bus.inst_req   = 1'b0;
    bus.inst_addr  = 32'h0;
    bus.data_req   = 1'b0;
    bus.data_wr    = 1'b0;
    bus.data_size  = 2'd0;
    bus.data_wstrb = 4'h0;
    bus.data_addr  = 32'h0;
    bus.data_wdata = 32'h0;
    bus.mem_rdata  = 32'h0;

    // Reset state. While resetn is low, requests must not be granted.
    #3;
    chk_idle_bus("rst");
    chk("rst_idok", bus.inst_data_ok, 32'd0);
    chk("rst_ddok", bus.data_data_ok, 32'd0);
    bus.inst_req = 1'b1;
    bus.data_req = 1'b1;
    #1;
    chk("rst_req_iaok", bus.inst_addr_ok, 32'd0);
    chk("rst_req_daok", bus.data_addr_ok, 32'd0);
    chk("rst_req_en",   bus.mem_en,       32'd0);
    next_cycle();

    // Single fetch in the first cycle after reset is released.
    resetn = 1'b1;
    bus.data_req  = 1'b0;
    bus.inst_addr = 32'h1C00_0000;
    #3;
    chk("fetch_iaok", bus.inst_addr_ok, 32'd1);
    chk("fetch_daok", bus.data_addr_ok, 32'd0);
    chk("fetch_en",   bus.mem_en,       32'd1);
    chk("fetch_addr", bus.mem_addr,     32'h1C00_0000);
    chk("fetch_size", bus.mem_size,     32'd2);
    chk("fetch_wen",  bus.mem_wen,      32'd0);
    chk("fetch_wd",   bus.mem_wdata,    32'd0);
    next_cycle();
    bus.inst_req  = 1'b0;
    bus.mem_rdata = 32'h0280_0C0C;
    #3;
    chk("fetch_idok",  bus.inst_data_ok, 32'd1);
    chk("fetch_rdata", bus.inst_rdata,   32'h0280_0C0C);
    chk("fetch_ddok",  bus.data_data_ok, 32'd0);
    chk_idle_bus("fetch_idle");
    next_cycle();
    #3;
    chk("fetch_idok_gone", bus.inst_data_ok, 32'd0);
    next_cycle();

    // Half-word store.
    bus.data_req   = 1'b1;
    bus.data_wr    = 1'b1;
    bus.data_size  = 2'd1;
    bus.data_wstrb = 4'b0011;
    bus.data_addr  = 32'h0000_1000;
    bus.data_wdata = 32'hABCD_1234;
    #3;
    chk("st_daok", bus.data_addr_ok, 32'd1);
    chk("st_wen",  bus.mem_wen,      32'h3);
    chk("st_size", bus.mem_size,     32'd1);
    chk("st_addr", bus.mem_addr,     32'h0000_1000);
    chk("st_wd",   bus.mem_wdata,    32'hABCD_1234);
    next_cycle();
    bus.data_req = 1'b0;
    bus.data_wr  = 1'b0;
    #3;
    chk("st_ddok", bus.data_data_ok, 32'd1);
    chk("st_idok", bus.inst_data_ok, 32'd0);
    next_cycle();

    // Load request with a stale wstrb must not write.
    bus.data_req  = 1'b1;
    bus.data_size = 2'd2;
    bus.data_addr = 32'h0000_0200;
    bus.inst_addr = 32'h0000_0100;
    #3;
    chk("ld_wen",  bus.mem_wen,  32'd0);
    chk("ld_size", bus.mem_size, 32'd2);
    next_cycle();

    // Both requesters held. The expected grant order is D,D,D,D,I,D,D,D,D,I.
    p_v = 1'b1;
    p_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      e_i = ((k % 5) == 4);
      step_both("starve", e_i, p_v, p_i);
      p_i = e_i;
    end

    // Alternating stream. Each cycle has one grant, and the previous owner gets data_ok.
    for (int k = 0; k < 8; k++) begin
      e_i = ((k % 2) == 0);
      bus.inst_req  = e_i;
      bus.data_req  = ~e_i;
      bus.mem_rdata = 32'h5A00_0000 + 32'(k);
      #3;
      chk("alt_iaok", bus.inst_addr_ok, {31'd0, e_i});
      chk("alt_daok", bus.data_addr_ok, {31'd0, ~e_i});
      chk("alt_en",   bus.mem_en,       32'd1);
      chk("alt_idok", bus.inst_data_ok, {31'd0, p_i});
      chk("alt_ddok", bus.data_data_ok, {31'd0, ~p_i});
      p_i = e_i;
      next_cycle();
    end
    bus.inst_req = 1'b0;
    bus.data_req = 1'b0;
    #3;
    chk("alt_last_ddok", bus.data_data_ok, 32'd1);
    chk("alt_last_idok", bus.inst_data_ok, 32'd0);
    next_cycle();

    // Data wins 3 times and then drops. The fetch is granted in the next cycle, and the counter restarts.
    p_v = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step_both("drop", 1'b0, p_v, 1'b0);
      p_v = 1'b1;
    end
    bus.inst_req = 1'b1;
    bus.data_req = 1'b0;
    #3;
    chk("drop_iaok", bus.inst_addr_ok, 32'd1);
    chk("drop_daok", bus.data_addr_ok, 32'd0);
    next_cycle();
    p_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      e_i = (k == 4);
      step_both("after_drop", e_i, 1'b1, p_i);
      p_i = e_i;
    end

    // A cycle with inst_req low clears a partly built count.
    for (int k = 0; k < 3; k++) begin
      step_both("pre_clr", 1'b0, 1'b1, p_i);
      p_i = 1'b0;
    end
    bus.inst_req = 1'b0;
    bus.data_req = 1'b1;
    #3;
    chk("clr_daok", bus.data_addr_ok, 32'd1);
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      e_i = (k == 4);
      step_both("post_clr", e_i, 1'b1, p_i);
      p_i = e_i;
    end

    // Reset in the cycle after a data load grant. The in-flight response is dropped, and the counter clears.
    for (int k = 0; k < 3; k++) begin
      step_both("pre_rst", 1'b0, 1'b1, p_i);
      p_i = 1'b0;
    end
    resetn = 1'b0;
    #3;
    chk_idle_bus("mid_rst");
    chk("mid_rst_ddok", bus.data_data_ok, 32'd0);
    chk("mid_rst_idok", bus.inst_data_ok, 32'd0);
    next_cycle();
    #3;
    chk("mid_rst2_en",   bus.mem_en,       32'd0);
    chk("mid_rst2_ddok", bus.data_data_ok, 32'd0);
    next_cycle();
    resetn = 1'b1;
    p_v = 1'b0;
    p_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      e_i = (k == 4);
      step_both("post_rst", e_i, p_v, p_i);
      p_v = 1'b1;
      p_i = e_i;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
